neuron_step_scheduler: RTL and testbench

Time-multiplexed controller that sequences one shared ADLIF neuron-update datapath across N_NEURONS virtual neurons per simulation time step. It owns per-neuron membrane-voltage and adaptive-threshold state and fetches each neuron's input current from the crossbar read path. It issues the update, writes results back and emits spike events toward the crossbar row driver. It sits between the crossbar column readout and the spike-event fabric.

---
 rtl/neuron_step_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_neuron_step_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_step_scheduler.sv
// neuron_step_scheduler
//
// Sequences one shared ADLIF neuron-update datapath across N_NEURONS virtual
// neurons per time step. Holds per-neuron membrane voltage and adaptive
// threshold, fetches each neuron's input current from the crossbar read path,
// launches the update, writes the result back and emits spike events.
//
// Optional feature macro: SCHED_REFRACTORY_EN
//   When defined, each neuron carries a refractory counter loaded with
//   REFRAC_STEPS on a spike. While it is non-zero the neuron is skipped: no
//   current fetch, no update, voltage pinned to REST_V, counter decremented.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   tick              : one-cycle pulse that starts a time step (IDLE only)
//   busy, step_done   : step in progress / one-cycle end-of-step pulse
//   tick_overrun      : sticky, tick seen while not IDLE (cleared by rst)
//   step_cnt          : completed-step counter, wraps
//   cur_req/cur_idx   : current request, held until cur_valid
//   cur_valid/cur_data: current response
//   upd_start         : one-cycle datapath launch
//   upd_v_in/th_in/i_in : operands, held from upd_start until upd_done
//   upd_done, upd_v_out, upd_th_out, upd_spike : datapath result
//   spk_valid/spk_ready/spk_idx/spk_step : spike event handshake
//   mon_idx, mon_v, mon_th : combinational state readback
//   o_dbg_state       : current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where both the valid side
// (cur_req, spk_valid) and the ready side (cur_valid, spk_ready) are high; the
// valid side holds its request and payload stable until that edge.
module neuron_step_scheduler #(
    parameter int                    N_NEURONS    = 16,
    parameter int                    V_W          = 16,
    parameter logic signed [V_W-1:0] REST_V       = 16'sh0000,
    parameter logic signed [V_W-1:0] TH_INIT      = 16'sh0A00,
    parameter int                    REFRAC_STEPS = 2,
    localparam int                   IW           = $clog2(N_NEURONS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    output logic           busy,
    output logic           step_done,
    output logic           tick_overrun,
    output logic [15:0]    step_cnt,
    output logic           cur_req,
    output logic [IW-1:0]  cur_idx,
    input  logic           cur_valid,
    input  logic [V_W-1:0] cur_data,
    output logic           upd_start,
    output logic [V_W-1:0] upd_v_in,
    output logic [V_W-1:0] upd_th_in,
    output logic [V_W-1:0] upd_i_in,
    input  logic           upd_done,
    input  logic [V_W-1:0] upd_v_out,
    input  logic [V_W-1:0] upd_th_out,
    input  logic           upd_spike,
    output logic           spk_valid,
    input  logic           spk_ready,
    output logic [IW-1:0]  spk_idx,
    output logic [15:0]    spk_step,
    input  logic [IW-1:0]  mon_idx,
    output logic [V_W-1:0] mon_v,
    output logic [V_W-1:0] mon_th,
    output logic [2:0]     o_dbg_state
);

    // Elaboration-time sanity check on the configuration.
    generate
        if (N_NEURONS < 2 || REFRAC_STEPS < 1) begin : g_bad_params
            $error("neuron_step_scheduler: need N_NEURONS >= 2 and REFRAC_STEPS >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_EMIT  = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [15:0]      r_step_cnt;
    logic             r_overrun;
    logic [V_W-1:0]   r_op_v;
    logic [V_W-1:0]   r_op_th;
    logic [V_W-1:0]   r_op_i;
    // Datapath results are only valid for the single upd_done cycle, so they
    // are captured in WAIT and committed to the arrays in WRITE.
    logic [V_W-1:0]   r_res_v;
    logic [V_W-1:0]   r_res_th;
    logic             r_res_spk;
    logic [V_W-1:0]   r_v  [N_NEURONS];
    logic [V_W-1:0]   r_th [N_NEURONS];
    logic             w_skip;

`ifdef SCHED_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_STEPS + 1);
    logic [RW-1:0]    r_ref [N_NEURONS];
    assign w_skip = (r_ref[r_idx] != '0);
`else
    assign w_skip = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (tick) w_next = S_FETCH;
            S_FETCH: begin
                if (w_skip)         w_next = S_NEXT;
                else if (cur_valid) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (upd_done) w_next = S_WRITE;
            S_WRITE: w_next = r_res_spk ? S_EMIT : S_NEXT;
            S_EMIT:  if (spk_ready) w_next = S_NEXT;
            S_NEXT:  w_next = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_step_cnt <= '0;
            r_overrun  <= 1'b0;
            r_op_v     <= '0;
            r_op_th    <= '0;
            r_op_i     <= '0;
            r_res_v    <= '0;
            r_res_th   <= '0;
            r_res_spk  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i]  <= REST_V;
                r_th[i] <= TH_INIT;
`ifdef SCHED_REFRACTORY_EN
                r_ref[i] <= '0;
`endif
            end
        end else begin
            r_state <= w_next;
            if (tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (tick) r_idx <= '0;
                S_FETCH: begin
`ifdef SCHED_REFRACTORY_EN
                    if (w_skip) begin
                        r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
                        r_v[r_idx]   <= REST_V;
                    end else
`endif
                    if (cur_valid) begin
                        r_op_i  <= cur_data;
                        r_op_v  <= r_v[r_idx];
                        r_op_th <= r_th[r_idx];
                    end
                end
                S_WAIT: begin
                    if (upd_done) begin
                        r_res_v   <= upd_v_out;
                        r_res_th  <= upd_th_out;
                        r_res_spk <= upd_spike;
                    end
                end
                S_WRITE: begin
                    r_th[r_idx] <= r_res_th;
                    r_v[r_idx]  <= r_res_spk ? REST_V : r_res_v;
`ifdef SCHED_REFRACTORY_EN
                    if (r_res_spk) r_ref[r_idx] <= RW'(REFRAC_STEPS);
`endif
                end
                S_NEXT: if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                S_DONE: r_step_cnt <= r_step_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign step_done    = (r_state == S_DONE);
    assign tick_overrun = r_overrun;
    assign step_cnt     = r_step_cnt;
    assign cur_req      = (r_state == S_FETCH) && !w_skip;
    assign cur_idx      = r_idx;
    assign upd_start    = (r_state == S_ISSUE);
    assign upd_v_in     = r_op_v;
    assign upd_th_in    = r_op_th;
    assign upd_i_in     = r_op_i;
    assign spk_valid    = (r_state == S_EMIT);
    assign spk_idx      = r_idx;
    assign spk_step     = r_step_cnt;
    assign mon_v        = r_v[mon_idx];
    assign mon_th       = r_th[mon_idx];
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
module tb_neuron_step_scheduler;

    localparam int         N       = 16;
    localparam logic [2:0] ST_WAIT = 3'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        busy, step_done, tick_overrun;
    logic [15:0] step_cnt;
    logic        cur_req;
    logic [3:0]  cur_idx;
    logic        cur_valid;
    logic [15:0] cur_data;
    logic        upd_start;
    logic [15:0] upd_v_in, upd_th_in, upd_i_in;
    logic        upd_done = 1'b0;
    logic [15:0] upd_v_out, upd_th_out;
    logic        upd_spike;
    logic        spk_valid;
    logic        spk_ready = 1'b1;
    logic [3:0]  spk_idx;
    logic [15:0] spk_step;
    logic [3:0]  mon_idx = 4'd0;
    logic [15:0] mon_v, mon_th;
    logic [2:0]  dbg_state;

    logic        spike_en = 1'b0;
    logic [3:0]  spike_idx = 4'd0;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    neuron_step_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick),
        .busy(busy), .step_done(step_done), .tick_overrun(tick_overrun),
        .step_cnt(step_cnt),
        .cur_req(cur_req), .cur_idx(cur_idx), .cur_valid(cur_valid), .cur_data(cur_data),
        .upd_start(upd_start), .upd_v_in(upd_v_in), .upd_th_in(upd_th_in), .upd_i_in(upd_i_in),
        .upd_done(upd_done), .upd_v_out(upd_v_out), .upd_th_out(upd_th_out), .upd_spike(upd_spike),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx), .spk_step(spk_step),
        .mon_idx(mon_idx), .mon_v(mon_v), .mon_th(mon_th),
        .o_dbg_state(dbg_state)
    );

    // ---------------- zero-latency responders ----------------
    // Current source answers in the request cycle; datapath answers one cycle
    // after launch, with v+1.0 and th+0.125, firing only the selected neuron.
    assign cur_valid  = cur_req;
    assign cur_data   = 16'h0040 + {12'h000, cur_idx};
    always @(posedge clk) upd_done <= upd_start;
    assign upd_v_out  = upd_v_in + 16'h0100;
    assign upd_th_out = upd_th_in + 16'h0020;
    assign upd_spike  = upd_done && spike_en && (cur_idx == spike_idx);

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] exp_v;
        logic [15:0] exp_th;
    } mon_vec_t;

    mon_vec_t tbl[N];

    task automatic fill_table(input logic [15:0] v, input logic [15:0] th);
        for (int i = 0; i < N; i++) begin
            tbl[i].idx    = 4'(i);
            tbl[i].exp_v  = v;
            tbl[i].exp_th = th;
        end
    endtask

    task automatic check_table(input string tag);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            mon_idx = tbl[i].idx;
            #1;
            check($sformatf("%s_mon_v[%0d]", tag, i), {16'h0, mon_v}, {16'h0, tbl[i].exp_v});
            check($sformatf("%s_mon_th[%0d]", tag, i), {16'h0, mon_th}, {16'h0, tbl[i].exp_th});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one full step. cycles counts the tick cycle as cycle 1 and ends at
    // the cycle where step_done is high; fetch2 counts requests for neuron 2.
    task automatic run_step(output int cycles, output int fetch2);
        bit done;
        done   = 1'b0;
        fetch2 = 0;
        @(negedge clk);
        cycles = 1;
        tick   = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            tick = 1'b0;
            cycles++;
            if (cycles == 2) begin
                check("cur_req_after_tick", {31'h0, cur_req}, 32'd1);
                check("cur_idx_after_tick", {28'h0, cur_idx}, 32'd0);
            end
            if (cur_req && cur_idx == 4'd2) fetch2++;
            if (upd_start) check("upd_i_in", {16'h0, upd_i_in}, {16'h0, 16'h0040 + {12'h000, cur_idx}});
            if (step_done) done = 1'b1;
        end
        if (!done) check("step_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_spk_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            tick = 1'b0;
            if (spk_valid) seen = 1'b1;
        end
        if (!seen) check({tag, "_spk_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_step_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            tick = 1'b0;
            if (step_done) seen = 1'b1;
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc, f2, n_hold, n_done;
        bit found;

        // Reset state
        do_reset();
        check("rst_busy",      {31'h0, busy},         32'd0);
        check("rst_step_done", {31'h0, step_done},    32'd0);
        check("rst_overrun",   {31'h0, tick_overrun}, 32'd0);
        check("rst_cur_req",   {31'h0, cur_req},      32'd0);
        check("rst_upd_start", {31'h0, upd_start},    32'd0);
        check("rst_spk_valid", {31'h0, spk_valid},    32'd0);
        check("rst_step_cnt",  {16'h0, step_cnt},     32'd0);
        check("rst_cur_idx",   {28'h0, cur_idx},      32'd0);
        check("rst_spk_idx",   {28'h0, spk_idx},      32'd0);
        check("rst_spk_step",  {16'h0, spk_step},     32'd0);
        check("rst_upd_v_in",  {16'h0, upd_v_in},     32'd0);
        check("rst_upd_th_in", {16'h0, upd_th_in},    32'd0);
        check("rst_upd_i_in",  {16'h0, upd_i_in},     32'd0);
        fill_table(16'h0000, 16'h0A00);
        check_table("reset");

        // One full step without spikes: 1 + 5*16 + 1 = 82 cycles
        run_step(cyc, f2);
        check("step_cycles", cyc, 32'd82);
        @(negedge clk);
        check("step_done_pulse", {31'h0, step_done}, 32'd0);
        check("busy_after_step", {31'h0, busy},      32'd0);
        check("step_cnt_1",      {16'h0, step_cnt},  32'd1);
        fill_table(16'h0100, 16'h0A20);
        check_table("step1");

        // Tick during WAIT of neuron 3 and again in DONE
        do_reset();
        tick = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            tick = 1'b0;
            if (dbg_state == ST_WAIT && cur_idx == 4'd3) found = 1'b1;
        end
        if (!found) check("ovr_wait3_timeout", 32'd0, 32'd1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("ovr_set",  {31'h0, tick_overrun}, 32'd1);
        check("ovr_busy", {31'h0, busy},         32'd1);
        wait_step_done("ovr");
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("ovr_done_tick_dropped", {31'h0, busy}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (step_done) n_done++;
        end
        check("ovr_no_extra_done", n_done, 32'd0);
        check("ovr_step_cnt", {16'h0, step_cnt},     32'd1);
        check("ovr_sticky",   {31'h0, tick_overrun}, 32'd1);

        // Neuron 5 spikes, downstream stalls 3 cycles
        do_reset();
        spike_en  = 1'b1;
        spike_idx = 4'd5;
        spk_ready = 1'b0;
        tick      = 1'b1;
        wait_spk_valid("spk");
        n_hold = 0;
        for (int k = 0; k < 20 && spk_valid; k++) begin
            n_hold++;
            check("spk_idx",  {28'h0, spk_idx},  32'd5);
            check("spk_step", {16'h0, spk_step}, 32'd0);
            if (n_hold == 4) spk_ready = 1'b1;
            @(negedge clk);
        end
        check("spk_hold_cycles", n_hold, 32'd4);
        wait_step_done("spk");
        spike_en = 1'b0;
        fill_table(16'h0100, 16'h0A20);
        tbl[5].exp_v = 16'h0000;
        check_table("spike");

        // Reset while an event is stalled in EMIT (step_cnt is 1 here)
        spike_en  = 1'b1;
        spk_ready = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        wait_spk_valid("rst_emit");
        check("rst_emit_spk_step", {16'h0, spk_step}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_emit_spk_valid", {31'h0, spk_valid}, 32'd0);
        check("rst_emit_busy",      {31'h0, busy},      32'd0);
        check("rst_emit_step_cnt",  {16'h0, step_cnt},  32'd0);
        check("rst_emit_spk_idx",   {28'h0, spk_idx},   32'd0);
        rst       = 1'b0;
        spike_en  = 1'b0;
        spk_ready = 1'b1;
        fill_table(16'h0000, 16'h0A00);
        check_table("rst_emit");
        run_step(cyc, f2);
        check("rst_emit_restart_cycles", cyc, 32'd82);

`ifdef SCHED_REFRACTORY_EN
        // Neuron 2 spikes in step 0, is skipped in steps 1 and 2
        do_reset();
        spike_en  = 1'b1;
        spike_idx = 4'd2;
        run_step(cyc, f2);
        check("ref_s0_fetch2", f2, 32'd1);
        spike_en = 1'b0;
        run_step(cyc, f2);
        check("ref_s1_fetch2", f2, 32'd0);
        check("ref_s1_cycles", cyc, 32'd79);
        run_step(cyc, f2);
        check("ref_s2_fetch2", f2, 32'd0);
        @(negedge clk);
        mon_idx = 4'd2;
        #1;
        check("ref_s2_mon_v2", {16'h0, mon_v}, 32'd0);
        run_step(cyc, f2);
        check("ref_s3_fetch2", f2, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
